// File: rtl/egress_eth_parser.sv
// Ethernet header parser on the NMU egress path: passes the stream through untouched
// and produces per-beat route/poison/config side-channel signals for egress filtering.
module egress_eth_parser #(
  parameter int AXIS_BUS_WIDTH       = 64,
  parameter int AXIS_ID_WIDTH        = 4,
  parameter int AXIS_DEST_WIDTH      = 4,
  parameter int INCLUDE_CONFIG_ETYPE = 1,
  parameter int NUM_AXIS_ID          = 2**AXIS_ID_WIDTH,
  parameter int NUM_BUS_BYTES        = AXIS_BUS_WIDTH / 8,
  parameter int EFF_ID_WIDTH         = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  parameter int EFF_DEST_WIDTH       = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [EFF_ID_WIDTH-1:0]     axis_in_tid,
  input  logic [EFF_DEST_WIDTH-1:0]   axis_in_tdest,
  input  logic [NUM_BUS_BYTES-1:0]    axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [EFF_ID_WIDTH-1:0]     axis_out_tid,
  output logic [EFF_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic [NUM_BUS_BYTES-1:0]    axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  output logic [NUM_AXIS_ID-1:0]      route_mask,
  output logic                        poisoned,
  output logic                        parsing_done,
  output logic                        next_is_config,
  output logic [EFF_ID_WIDTH-1:0]     parser_sel_id,
  input  logic [48*NUM_AXIS_ID-1:0]   id_mac_addrs,
  input  logic [NUM_AXIS_ID-1:0]      id_mac_valid,
  input  logic [47:0]                 src_mac_expected,
  input  logic                        enforce_src_mac,
  input  logic [15:0]                 config_etype,
  output logic [31:0]                 poison_count
);

  localparam int LAST_HDR_BEAT = 13 / NUM_BUS_BYTES;
  localparam int LAST_HDR_OFS  = 13 % NUM_BUS_BYTES;

  typedef enum logic {S_HDR, S_DONE} state_t;

  state_t      state;
  logic [1:0]  beat_cnt;
  logic        runt_reg;
  logic [31:0] poison_cnt_reg;

  logic        accept;
  logic        in_hdr;
  logic        hdr_beat;
  logic        runt;
  logic        multicast;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] etype;
  logic [7:0]  hdr_cur [14];
  logic [NUM_AXIS_ID-1:0] ucast_hit;
  logic [NUM_AXIS_ID-1:0] tid_bit;

  assign axis_in_tready  = axis_out_tready;
  assign axis_out_tdata  = axis_in_tdata;
  assign axis_out_tid    = axis_in_tid;
  assign axis_out_tdest  = axis_in_tdest;
  assign axis_out_tkeep  = axis_in_tkeep;
  assign axis_out_tlast  = axis_in_tlast;
  assign axis_out_tvalid = axis_in_tvalid;
  assign parser_sel_id   = axis_in_tid;
  assign poison_count    = poison_cnt_reg;

  assign accept   = axis_in_tvalid && axis_out_tready;
  assign in_hdr   = (state == S_HDR);
  assign hdr_beat = in_hdr && (beat_cnt == 2'(LAST_HDR_BEAT));

  // Each header byte reads live from the bus on its own beat, otherwise from its capture register.
  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_hdr
      localparam int BEAT = gi / NUM_BUS_BYTES;
      localparam int OFS  = gi % NUM_BUS_BYTES;
      logic       live;
      logic [7:0] byte_reg;

      assign live        = in_hdr && (beat_cnt == 2'(BEAT));
      assign hdr_cur[gi] = live ? axis_in_tdata[8*OFS+7 -: 8] : byte_reg;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
          byte_reg <= '0;
        else if (accept && live)
          byte_reg <= axis_in_tdata[8*OFS+7 -: 8];
      end
    end
  endgenerate

  assign dest_mac  = {hdr_cur[0], hdr_cur[1], hdr_cur[2], hdr_cur[3], hdr_cur[4], hdr_cur[5]};
  assign src_mac   = {hdr_cur[6], hdr_cur[7], hdr_cur[8], hdr_cur[9], hdr_cur[10], hdr_cur[11]};
  assign etype     = {hdr_cur[12], hdr_cur[13]};
  assign multicast = dest_mac[40];

  generate
    for (genvar gi = 0; gi < NUM_AXIS_ID; gi++) begin : g_match
      assign ucast_hit[gi] = id_mac_valid[gi] && (dest_mac == id_mac_addrs[48*gi +: 48]);
    end
  endgenerate

  assign tid_bit = NUM_AXIS_ID'(1) << axis_in_tid;

  // A packet ending before byte 13, or with byte 13 masked off, is a runt.
  assign runt = in_hdr ? ((axis_in_tlast && !hdr_beat) ||
                          (hdr_beat && !axis_in_tkeep[LAST_HDR_OFS]))
                       : runt_reg;

  assign route_mask     = runt ? '0 : ((multicast ? id_mac_valid : ucast_hit) & ~tid_bit);
  assign poisoned       = runt || (enforce_src_mac && (src_mac != src_mac_expected));
  assign parsing_done   = axis_in_tvalid && (!in_hdr || hdr_beat || axis_in_tlast);
  assign next_is_config = (INCLUDE_CONFIG_ETYPE != 0) && (etype == config_etype);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_HDR;
      beat_cnt       <= '0;
      runt_reg       <= 1'b0;
      poison_cnt_reg <= '0;
    end else if (accept) begin
      if (axis_in_tlast) begin
        state    <= S_HDR;
        beat_cnt <= '0;
        runt_reg <= 1'b0;
        if (poisoned && (poison_cnt_reg != 32'hFFFF_FFFF))
          poison_cnt_reg <= poison_cnt_reg + 32'd1;
      end else if (hdr_beat) begin
        state    <= S_DONE;
        runt_reg <= !axis_in_tkeep[LAST_HDR_OFS];
      end else if (in_hdr) begin
        beat_cnt <= beat_cnt + 2'd1;
      end
    end
  end

endmodule

// File: doc/egress_eth_parser.md
Name: egress_eth_parser

Overview:
- Ethernet header parser that sits directly upstream of egress filtering in the NMU egress path.
- Passes the AXI-Stream packet through with zero latency.
- Alongside each beat, produces the side-channel signals consumed by egress filtering: route_mask, poisoned, parsing_done, next_is_config.
- Decodes destination MAC against per-ID MAC addresses, enforces per-ID source MAC, and detects the configuration EtherType.

Parameters:
- AXIS_BUS_WIDTH, 64, data width; multiple of 64.
- AXIS_ID_WIDTH, 4, TID width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH.
- AXIS_DEST_WIDTH, 4, TDEST width (pass-through only).
- INCLUDE_CONFIG_ETYPE, 1, when 0 next_is_config is tied to 0.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- axis_in_tdata/tid/tdest/tkeep/tlast/tvalid  in  AXIS_BUS_WIDTH/EFF_ID_WIDTH/EFF_DEST_WIDTH/NUM_BUS_BYTES/1/1  input stream
- axis_in_tready  out  1  equals axis_out_tready
- axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  same widths  output stream, combinational copy of input
- axis_out_tready  in  1  downstream ready
- route_mask  out  NUM_AXIS_ID  internal destinations of the packet
- poisoned  out  1  packet must be dropped
- parsing_done  out  1  side channel valid for this beat
- next_is_config  out  1  EtherType equals config_etype
- parser_sel_id  out  EFF_ID_WIDTH  equals axis_in_tid; selects per-ID config
- id_mac_addrs  in  48*NUM_AXIS_ID  MAC of ID i at [48i+47:48i]
- id_mac_valid  in  NUM_AXIS_ID  ID i has an assigned MAC
- src_mac_expected  in  48  MAC of the selected ID
- enforce_src_mac  in  1  check source MAC for the selected ID
- config_etype  in  16  configuration EtherType
- poison_count  out  32  saturating count of poisoned packets

Behaviour:
- Byte k of the packet is at beat k/NUM_BUS_BYTES, bits [8*(k%NUM_BUS_BYTES)+7 -:8]; beat 0 is the first beat after reset or after an accepted tlast.
- Header layout: dest MAC bytes 0-5, source MAC bytes 6-11, EtherType bytes 12-13. Byte 0 maps to MAC[47:40]; EtherType is big-endian.
- Beat accepted = axis_in_tvalid && axis_out_tready. Data, tid, tdest, tkeep, tlast and tvalid pass through combinationally with zero latency.
- State machine:
  - HDR: beat_cnt counts accepted beats. Header bytes from earlier beats are held in registers. Side-channel outputs combine the registered bytes with the current beat.
  - HDR -> DONE: on acceptance of the beat containing byte 13 when that beat is not tlast.
  - HDR -> HDR with beat_cnt cleared: on any accepted tlast.
  - DONE: header registers frozen; side-channel outputs constant.
  - DONE -> HDR: on accepted tlast.
- parsing_done: 1 on the beat containing byte 13 and on every later beat of the packet. Also 1 on a runt's tlast beat. 0 otherwise.
- Runt: packet shorter than 14 bytes, meaning tlast before the byte-13 beat, or tkeep bit for byte 13 clear on that beat. Required on the tlast beat: parsing_done=1, poisoned=1, route_mask=0.
- route_mask:
  - Multicast (dest byte 0 bit 0 = 1): id_mac_valid with bit tid cleared (no hairpin).
  - Otherwise: bit i = id_mac_valid[i] && dest==id_mac[i]; bit tid is forced to 0.
- poisoned = runt || (enforce_src_mac && src != src_mac_expected).
- next_is_config = INCLUDE_CONFIG_ETYPE && EtherType==config_etype.
- While parsing_done=0, route_mask, poisoned and next_is_config are don't-care; the bench checks them only when parsing_done=1.
- Config inputs may change only between packets. Each side-channel output is a function of the inputs presented on the same beat.
- poison_count: increments once per packet, on the accepted tlast beat of a poisoned packet; saturates at 32'hFFFFFFFF.
- Reset values: state=HDR, beat_cnt=0, header registers=0, poison_count=0.
- Reset mid-packet: parser returns to HDR; the next accepted beat is treated as byte 0.
- tvalid with tready=0: no state change; outputs remain stable.

Test Plan (64-bit bus, AXIS_ID_WIDTH=4; mac[i]=48'h02000000000i; id_mac_valid=16'h00FF):
- Unicast: dest=mac[3], tid=1, src=mac[1], enforce=1, 3-beat packet -> beat0 parsing_done=0; beats 1-2 parsing_done=1, route_mask=16'h0008, poisoned=0.
- Broadcast: dest=FF..FF from tid=2 -> route_mask=16'h00FB. Same packet with dest=mac[2] -> route_mask=16'h0000.
- Spoofed source: src=mac[5], tid=1, enforce=1 -> poisoned=1 on beats 1 through tlast; poison_count 0 -> 1. With enforce=0 -> poisoned=0, count unchanged.
- Config EtherType: config_etype=16'h88B5, EtherType bytes 88,B5 -> next_is_config=1. With INCLUDE_CONFIG_ETYPE=0 -> next_is_config=0.
- Runt: 10-byte packet, beat1 tkeep=8'h03, tlast=1 -> parsing_done=1, poisoned=1, route_mask=0. Following unicast packet parses correctly.
- Backpressure and reset:
  - axis_out_tready toggled every cycle during a header -> identical results to the unstalled run.
  - aresetn asserted after beat 0 -> next beat is parsed as byte 0 and yields correct route_mask.
